// File: rtl/hs_burst_pkg.sv
// ---------------------------------------------------------------------------
// hs_burst_pkg
// Shared definitions for the hs_burst_source traffic generator:
//   - default width parameters for data, burst length and gap counter
//   - FSM state encoding hs_burst_state_e (explicitly encoded so the values
//     stay fixed for anyone decoding the state bits in waveforms)
// ---------------------------------------------------------------------------
package hs_burst_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 8;
  localparam int GAP_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } hs_burst_state_e;

endpackage

// File: rtl/hs_gap_timer.sv
// ---------------------------------------------------------------------------
// hs_gap_timer
// Loadable down-counter that times the idle cycles between beats.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   load_i        load load_val_i into the counter this edge
//   load_val_i    value to load (number of idle cycles minus one)
//   expired_o     counter is at zero (final idle cycle)
// Loading N gives N+1 cycles before the counter is seen expired, so the
// owner loads gap-1 to get exactly gap idle cycles.
// ---------------------------------------------------------------------------
module hs_gap_timer
  import hs_burst_pkg::*;
#(
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [GAP_W-1:0] load_val_i,
  output logic             expired_o
);

  logic [GAP_W-1:0] cnt_q;
  logic [GAP_W-1:0] cnt_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - GAP_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops
  // update together at the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/hs_burst_source.sv
// ---------------------------------------------------------------------------
// hs_burst_source
// Burst generator driving a valid/ready channel with an arithmetic sequence.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start_i             command strobe (accepted only while idle)
//   len_i/base_i/       beats-1, first value, increment, idle cycles after
//   step_i/gap_i        each non-last beat; all sampled with start_i
//   busy_o              burst in progress (SEND or GAP)
//   done_o              one-cycle pulse after the last beat is accepted
//   valid_o/data_o/     downstream beat, registered; held stable until
//   last_o              accepted
//   ready_i             downstream ready
//   beat_cnt_o          beats accepted in the current or most recent burst
// ---------------------------------------------------------------------------
module hs_burst_source
  import hs_burst_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int GAP_W  = GAP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [DATA_W-1:0] base_i,
  input  logic [DATA_W-1:0] step_i,
  input  logic [GAP_W-1:0]  gap_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  input  logic              ready_i,
  output logic [LEN_W:0]    beat_cnt_o
);

  hs_burst_state_e   state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] step_q, step_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [LEN_W:0]    beat_cnt_q, beat_cnt_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timer_load;
  logic              timer_expired;

  hs_gap_timer #(.GAP_W(GAP_W)) u_gap_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timer_load),
    .load_val_i (gap_q - GAP_W'(1)),
    .expired_o  (timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    step_d     = step_q;
    len_d      = len_q;
    gap_d      = gap_q;
    beat_cnt_d = beat_cnt_q;
    timer_load = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          len_d      = len_i;
          step_d     = step_i;
          gap_d      = gap_i;
          data_d     = base_i;
          beat_cnt_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        // valid_q is always high here, so ready_i alone marks an accept.
        if (ready_i) begin
          beat_cnt_d = beat_cnt_q + (LEN_W+1)'(1);
          if (last_q) begin
            state_d = DONE;
          end else begin
            data_d = data_q + step_q;
            if (gap_q != '0) begin
              state_d    = GAP;
              timer_load = 1'b1;
            end
          end
        end
      end
      GAP: begin
        if (timer_expired) state_d = SEND;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from next-state values and registered, so none of
    // them has a combinational path from ready_i or start_i.
    valid_d = (state_d == SEND);
    busy_d  = (state_d == SEND) || (state_d == GAP);
    done_d  = (state_d == DONE);
    last_d  = (state_d == SEND) && (beat_cnt_d == {1'b0, len_d});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      data_q     <= '0;
      step_q     <= '0;
      len_q      <= '0;
      gap_q      <= '0;
      beat_cnt_q <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      step_q     <= step_d;
      len_q      <= len_d;
      gap_q      <= gap_d;
      beat_cnt_q <= beat_cnt_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign last_o     = last_q;
  assign beat_cnt_o = beat_cnt_q;

endmodule

// File: tb/tb_hs_burst_source.sv
// ---------------------------------------------------------------------------
// tb_hs_burst_source
// Directed bench for hs_burst_source with default widths (8/8/4).
// Inputs change and outputs are observed on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_hs_burst_source;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic [7:0] len_i;
  logic [7:0] base_i;
  logic [7:0] step_i;
  logic [3:0] gap_i;
  logic       busy_o;
  logic       done_o;
  logic       valid_o;
  logic [7:0] data_o;
  logic       last_o;
  logic       ready_i;
  logic [8:0] beat_cnt_o;

  int n_cmp = 0;
  int n_mis = 0;

  hs_burst_source dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .len_i      (len_i),
    .base_i     (base_i),
    .step_i     (step_i),
    .gap_i      (gap_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .last_o     (last_o),
    .ready_i    (ready_i),
    .beat_cnt_o (beat_cnt_o)
  );

  always #5 clk = ~clk;

  // Full view {busy,done,valid,last,data,beat_cnt}; control view omits data
  // for cycles where data_o carries no beat.
  logic [20:0] obs_full;
  logic [12:0] obs_ctl;
  assign obs_full = {busy_o, done_o, valid_o, last_o, data_o, beat_cnt_o};
  assign obs_ctl  = {busy_o, done_o, valid_o, last_o, beat_cnt_o};

  function automatic logic [20:0] full(logic b, logic d, logic v, logic l,
                                       logic [7:0] dat, logic [8:0] cnt);
    return {b, d, v, l, dat, cnt};
  endfunction

  function automatic logic [12:0] ctl(logic b, logic d, logic v, logic l,
                                      logic [8:0] cnt);
    return {b, d, v, l, cnt};
  endfunction

  task automatic issue_cmd(input logic [7:0] len, input logic [7:0] base,
                           input logic [7:0] step, input logic [3:0] gap);
    @(negedge clk);
    start_i = 1'b1;
    len_i   = len;
    base_i  = base;
    step_i  = step;
    gap_i   = gap;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [20:0] exp;
    rst = 1'b1; start_i = 1'b0; ready_i = 1'b0;
    len_i = '0; base_i = '0; step_i = '0; gap_i = '0;
    repeat (2) @(negedge clk);
    exp = '0;
    n_cmp++;
    if (obs_full !== exp) begin
      n_mis++;
      $display("FAIL reset_values: got %h want %h", obs_full, exp);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs_full !== exp) begin
      n_mis++;
      $display("FAIL idle_after_reset: got %h want %h", obs_full, exp);
    end
  endtask

  task automatic test_basic();
    logic [20:0] exp;
    logic [12:0] expc;
    ready_i = 1'b1;
    issue_cmd(8'd3, 8'h10, 8'd1, 4'd0);
    for (int i = 0; i < 4; i++) begin
      exp = full(1'b1, 1'b0, 1'b1, (i == 3), 8'h10 + 8'(i), 9'(i));
      n_cmp++;
      if (obs_full !== exp) begin
        n_mis++;
        $display("FAIL basic_beat%0d: got %h want %h", i, obs_full, exp);
      end
      @(negedge clk);
    end
    expc = ctl(1'b0, 1'b1, 1'b0, 1'b0, 9'd4);
    n_cmp++;
    if (obs_ctl !== expc) begin
      n_mis++;
      $display("FAIL basic_done: got %h want %h", obs_ctl, expc);
    end
    @(negedge clk);
    expc = ctl(1'b0, 1'b0, 1'b0, 1'b0, 9'd4);
    n_cmp++;
    if (obs_ctl !== expc) begin
      n_mis++;
      $display("FAIL basic_idle: got %h want %h", obs_ctl, expc);
    end
  endtask

  task automatic test_ready_toggle();
    int beats = 0;
    logic [9:0]  exp;
    logic [12:0] expc;
    ready_i = 1'b0;
    issue_cmd(8'd3, 8'h10, 8'd1, 4'd0);
    for (int cyc = 0; cyc < 20 && beats < 4; cyc++) begin
      // gap=0: valid must stay high with the current beat until accepted.
      exp = {1'b1, (beats == 3), 8'h10 + 8'(beats)};
      n_cmp++;
      if ({valid_o, last_o, data_o} !== exp) begin
        n_mis++;
        $display("FAIL toggle_cyc%0d: got %h want %h", cyc,
                 {valid_o, last_o, data_o}, exp);
      end
      ready_i = cyc[0];
      if (ready_i) beats++;
      @(negedge clk);
    end
    ready_i = 1'b1;
    n_cmp++;
    if (beats != 4) begin
      n_mis++;
      $display("FAIL toggle_beats: got %0d want 4", beats);
    end
    expc = ctl(1'b0, 1'b1, 1'b0, 1'b0, 9'd4);
    n_cmp++;
    if (obs_ctl !== expc) begin
      n_mis++;
      $display("FAIL toggle_done: got %h want %h", obs_ctl, expc);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [7:0]  vals [3] = '{8'hFE, 8'h01, 8'h04};
    logic [20:0] exp;
    logic [12:0] expc;
    ready_i = 1'b1;
    issue_cmd(8'd2, 8'hFE, 8'd3, 4'd0);
    for (int i = 0; i < 3; i++) begin
      exp = full(1'b1, 1'b0, 1'b1, (i == 2), vals[i], 9'(i));
      n_cmp++;
      if (obs_full !== exp) begin
        n_mis++;
        $display("FAIL wrap_beat%0d: got %h want %h", i, obs_full, exp);
      end
      @(negedge clk);
    end
    expc = ctl(1'b0, 1'b1, 1'b0, 1'b0, 9'd3);
    n_cmp++;
    if (obs_ctl !== expc) begin
      n_mis++;
      $display("FAIL wrap_done: got %h want %h", obs_ctl, expc);
    end
    @(negedge clk);
  endtask

  task automatic test_gap();
    logic [20:0] exp;
    logic [12:0] expc;
    ready_i = 1'b1;
    issue_cmd(8'd1, 8'h40, 8'd5, 4'd2);
    exp = full(1'b1, 1'b0, 1'b1, 1'b0, 8'h40, 9'd0);
    n_cmp++;
    if (obs_full !== exp) begin
      n_mis++;
      $display("FAIL gap_beat0: got %h want %h", obs_full, exp);
    end
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      expc = ctl(1'b1, 1'b0, 1'b0, 1'b0, 9'd1);
      n_cmp++;
      if (obs_ctl !== expc) begin
        n_mis++;
        $display("FAIL gap_idle%0d: got %h want %h", g, obs_ctl, expc);
      end
    end
    @(negedge clk);
    exp = full(1'b1, 1'b0, 1'b1, 1'b1, 8'h45, 9'd1);
    n_cmp++;
    if (obs_full !== exp) begin
      n_mis++;
      $display("FAIL gap_beat1: got %h want %h", obs_full, exp);
    end
    @(negedge clk);
    expc = ctl(1'b0, 1'b1, 1'b0, 1'b0, 9'd2);
    n_cmp++;
    if (obs_ctl !== expc) begin
      n_mis++;
      $display("FAIL gap_done: got %h want %h", obs_ctl, expc);
    end
    @(negedge clk);
  endtask

  task automatic test_len0_busy_start();
    logic [20:0] exp;
    logic [12:0] expc;
    ready_i = 1'b0;
    issue_cmd(8'd0, 8'h77, 8'd1, 4'd0);
    exp = full(1'b1, 1'b0, 1'b1, 1'b1, 8'h77, 9'd0);
    n_cmp++;
    if (obs_full !== exp) begin
      n_mis++;
      $display("FAIL len0_beat: got %h want %h", obs_full, exp);
    end
    // Second command while busy must not disturb the held beat.
    start_i = 1'b1; len_i = 8'd5; base_i = 8'h22; step_i = 8'd9; gap_i = 4'd3;
    @(negedge clk);
    start_i = 1'b0;
    n_cmp++;
    if (obs_full !== exp) begin
      n_mis++;
      $display("FAIL len0_busy_start: got %h want %h", obs_full, exp);
    end
    ready_i = 1'b1;
    @(negedge clk);
    expc = ctl(1'b0, 1'b1, 1'b0, 1'b0, 9'd1);
    n_cmp++;
    if (obs_ctl !== expc) begin
      n_mis++;
      $display("FAIL len0_done: got %h want %h", obs_ctl, expc);
    end
    // Start during the DONE cycle is ignored as well.
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    expc = ctl(1'b0, 1'b0, 1'b0, 1'b0, 9'd1);
    n_cmp++;
    if (obs_ctl !== expc) begin
      n_mis++;
      $display("FAIL len0_no_second_burst: got %h want %h", obs_ctl, expc);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [20:0] exp;
    logic [12:0] expc;
    ready_i = 1'b1;
    issue_cmd(8'd5, 8'h00, 8'd1, 4'd0);
    repeat (2) @(negedge clk);
    exp = full(1'b1, 1'b0, 1'b1, 1'b0, 8'h02, 9'd2);
    n_cmp++;
    if (obs_full !== exp) begin
      n_mis++;
      $display("FAIL midrst_beat2: got %h want %h", obs_full, exp);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp = '0;
    n_cmp++;
    if (obs_full !== exp) begin
      n_mis++;
      $display("FAIL midrst_zero: got %h want %h", obs_full, exp);
    end
    @(negedge clk);
    n_cmp++;
    if (obs_full !== exp) begin
      n_mis++;
      $display("FAIL midrst_no_done: got %h want %h", obs_full, exp);
    end
    issue_cmd(8'd5, 8'hA0, 8'h10, 4'd0);
    for (int i = 0; i < 6; i++) begin
      exp = full(1'b1, 1'b0, 1'b1, (i == 5), 8'hA0 + 8'(i * 16), 9'(i));
      n_cmp++;
      if (obs_full !== exp) begin
        n_mis++;
        $display("FAIL midrst_rerun_beat%0d: got %h want %h", i, obs_full, exp);
      end
      @(negedge clk);
    end
    expc = ctl(1'b0, 1'b1, 1'b0, 1'b0, 9'd6);
    n_cmp++;
    if (obs_ctl !== expc) begin
      n_mis++;
      $display("FAIL midrst_rerun_done: got %h want %h", obs_ctl, expc);
    end
    @(negedge clk);
  endtask

  task automatic test_max_len();
    logic [20:0] exp;
    logic [12:0] expc;
    ready_i = 1'b1;
    issue_cmd(8'hFF, 8'h00, 8'd1, 4'd0);
    for (int i = 0; i < 256; i++) begin
      exp = full(1'b1, 1'b0, 1'b1, (i == 255), 8'(i), 9'(i));
      n_cmp++;
      if (obs_full !== exp) begin
        n_mis++;
        $display("FAIL maxlen_beat%0d: got %h want %h", i, obs_full, exp);
      end
      @(negedge clk);
    end
    expc = ctl(1'b0, 1'b1, 1'b0, 1'b0, 9'd256);
    n_cmp++;
    if (obs_ctl !== expc) begin
      n_mis++;
      $display("FAIL maxlen_done: got %h want %h", obs_ctl, expc);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ready_toggle();
    test_wrap();
    test_gap();
    test_len0_busy_start();
    test_reset_mid_burst();
    test_max_len();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
